// File: rtl/mem_store_buf_pkg.sv
// Shared types and byte-enable constants for the MEM-stage store buffer.
package mem_store_buf_pkg;

    localparam int ENTRY_AW = 32;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {ST_NONE, ST_SB, ST_SH, ST_SW} st_type_e;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [31:0]         wdata;
        logic [3:0]          be;
    } entry_t;

endpackage

// File: rtl/mem_store_buf_store_align.sv
// Combinational lane steering, byte-enable generation and alignment check for sw/sh/sb.
module store_align
    import mem_store_buf_pkg::*;
(
    input  logic        sw,
    input  logic        sh,
    input  logic        sb,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] storedata,
    output logic        store_vld,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        err
);

    st_type_e st_type;

    always_comb begin
        st_type = ST_NONE;
        be      = '0;
        wdata   = '0;
        err     = 1'b0;
        case ({sw, sh, sb})
            3'b000: st_type = ST_NONE;
            3'b100: begin
                st_type = ST_SW;
                be      = BE_WORD;
                wdata   = storedata;
                err     = (addr_lo != 2'b00);
            end
            3'b010: begin
                st_type = ST_SH;
                be      = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata   = {2{storedata[15:0]}};
                err     = addr_lo[0];
            end
            3'b001: begin
                st_type = ST_SB;
                be      = BE_BYTE0 << addr_lo;
                wdata   = {4{storedata[7:0]}};
            end
            // more than one store flag: reject outright
            default: err = 1'b1;
        endcase
    end

    assign store_vld = (st_type != ST_NONE);

endmodule

// File: rtl/mem_store_buf.sv
// Store buffer: FIFO of steered writes drained over req/ack, with load-after-store hazard compare.
module mem_store_buf
    import mem_store_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sw,
    input  logic          sh,
    input  logic          sb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   storedata,
    input  logic          ld_check,
    input  logic [AW-1:0] ld_addr,
    output logic          stall,
    output logic          hazard,
    output logic          addr_err,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic        store_vld, align_err, full, push, pop;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    entry_t      new_ent, head;
    logic        unused_ld_lo;

    store_align u_align (
        .sw        (sw),
        .sh        (sh),
        .sb        (sb),
        .addr_lo   (addr[1:0]),
        .storedata (storedata),
        .store_vld (store_vld),
        .be        (st_be),
        .wdata     (st_wdata),
        .err       (align_err)
    );

    assign full     = (count_q == CW'(DEPTH));
    assign stall    = full;
    assign addr_err = align_err;
    // full blocks the push even when the head is acked this cycle
    assign push     = store_vld && !align_err && !full;
    assign pop      = mem_req && mem_ack;

    always_comb begin
        new_ent       = '0;
        new_ent.addr  = ENTRY_AW'(addr);
        new_ent.wdata = st_wdata;
        new_ent.be    = st_be;
    end

    always_comb begin
        ent_d    = ent_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            ent_d[wr_ptr_q]   = new_ent;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // outputs derive only from flops, so reset clears them without waiting for a clock
    assign head      = ent_q[rd_ptr_q];
    assign mem_req   = (count_q != '0);
    assign mem_addr  = mem_req ? {head.addr[AW-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? head.wdata : '0;
    assign mem_be    = mem_req ? head.be : '0;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_check && valid_q[i] && (ent_q[i].addr[AW-1:2] == ld_addr[AW-1:2]))
                hazard = 1'b1;
        end
    end

    assign unused_ld_lo = ^ld_addr[1:0];

endmodule
